// File: rtl/bitmap_bbox_scan_if.sv
// Start/busy/done handshake and result bus between the symbol-extraction
// buffer (master) and the bounding-box scanner (slave).
interface bitmap_bbox_scan_if #(
    parameter int COLS = 24,
    parameter int ROWS = 64
);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);

    logic                 wren;
    logic [ROWS*COLS-1:0] bitmap;
    logic                 busy;
    logic                 done;
    logic [CW-1:0]        left_margin;
    logic [CW-1:0]        right_margin;
    logic [RW-1:0]        top_margin;
    logic [RW-1:0]        bottom_margin;
    logic                 empty;

    modport master (
        output wren, bitmap,
        input  busy, done, left_margin, right_margin, top_margin, bottom_margin, empty
    );

    modport slave (
        input  wren, bitmap,
        output busy, done, left_margin, right_margin, top_margin, bottom_margin, empty
    );
endinterface

// File: rtl/bitmap_bbox_scan.sv
// Captures a COLS x ROWS symbol bitmap and scans it ROWS_PER_CYC rows per
// cycle to find the four empty margins used for glyph alignment.
//
// state  | meaning
// IDLE   | waiting for wren; results from the last scan held on the outputs
// SCAN   | consuming ROWS_PER_CYC rows of the shadow image per edge
// FINISH | registering margins/empty, pulsing done
module bitmap_bbox_scan #(
    parameter int COLS         = 24,
    parameter int ROWS         = 64,
    parameter int ROWS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bitmap_bbox_scan_if.slave bus
);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);
    localparam int N  = ROWS / ROWS_PER_CYC;

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t               state;
    logic [ROWS*COLS-1:0] shadow;
    logic [COLS-1:0]      col_acc;
    logic                 found;
    logic [RW-1:0]        first_row;
    logic [RW-1:0]        last_row;
    logic [RW-1:0]        row_idx;
    logic [RW-1:0]        scan_cnt;

    logic                 busy_q;
    logic                 done_q;
    logic                 empty_q;
    logic [CW-1:0]        left_q;
    logic [CW-1:0]        right_q;
    logic [RW-1:0]        top_q;
    logic [RW-1:0]        bottom_q;

    logic [COLS-1:0]      blk_or;
    logic                 blk_any;
    logic [RW-1:0]        blk_first;
    logic [RW-1:0]        blk_last;
    logic [CW-1:0]        lz;
    logic [CW-1:0]        tz;

    // The shadow image shifts up each scan edge, so the current block is always its top rows.
    always_comb begin
        blk_or    = '0;
        blk_any   = 1'b0;
        blk_first = '0;
        blk_last  = '0;
        for (int k = 0; k < ROWS_PER_CYC; k++) begin
            blk_or = blk_or | shadow[(ROWS-k)*COLS-1 -: COLS];
            if (|shadow[(ROWS-k)*COLS-1 -: COLS]) begin
                if (!blk_any) begin
                    blk_first = row_idx + RW'(k);
                end
                blk_any  = 1'b1;
                blk_last = row_idx + RW'(k);
            end
        end
    end

    // Column c lives at bit COLS-1-c: leading zeros give the left margin.
    always_comb begin
        lz = CW'(COLS);
        tz = CW'(COLS);
        for (int i = 0; i < COLS; i++) begin
            if (col_acc[i]) lz = CW'(COLS - 1 - i);
        end
        for (int i = COLS - 1; i >= 0; i--) begin
            if (col_acc[i]) tz = CW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            col_acc   <= '0;
            found     <= 1'b0;
            first_row <= '0;
            last_row  <= '0;
            row_idx   <= '0;
            scan_cnt  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            empty_q   <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            top_q     <= '0;
            bottom_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wren) begin
                        shadow    <= bus.bitmap;
                        col_acc   <= '0;
                        found     <= 1'b0;
                        first_row <= '0;
                        last_row  <= '0;
                        row_idx   <= '0;
                        scan_cnt  <= RW'(N - 1);
                        busy_q    <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    shadow  <= shadow << (ROWS_PER_CYC * COLS);
                    col_acc <= col_acc | blk_or;
                    if (blk_any) begin
                        if (!found) first_row <= blk_first;
                        found    <= 1'b1;
                        last_row <= blk_last;
                    end
                    row_idx <= row_idx + RW'(ROWS_PER_CYC);
                    if (scan_cnt == '0) begin
                        state <= FINISH;
                    end else begin
                        scan_cnt <= scan_cnt - RW'(1);
                    end
                end
                FINISH: begin
                    if (found) begin
                        left_q   <= lz;
                        right_q  <= tz;
                        top_q    <= first_row;
                        bottom_q <= RW'(ROWS - 1) - last_row;
                        empty_q  <= 1'b0;
                    end else begin
                        left_q   <= CW'(COLS);
                        right_q  <= CW'(COLS);
                        top_q    <= RW'(ROWS);
                        bottom_q <= RW'(ROWS);
                        empty_q  <= 1'b1;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.empty         = empty_q;
    assign bus.left_margin   = left_q;
    assign bus.right_margin  = right_q;
    assign bus.top_margin    = top_q;
    assign bus.bottom_margin = bottom_q;
endmodule
